// File: rtl/alu_exec_if.sv
// Request/response bundle for the ALU execute unit.
// The master side issues an op and takes the result; the slave side is the unit.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute unit: takes a 4-bit ALU control code and two operands, returns
// result / zero / illegal over a valid/ready pair.
// Optional macro ALU_FAST_SHIFT_EN: SLL becomes a single-cycle barrel shift and
// the iterative shift state, accumulator and counter are not built.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [1:0] IDLE  = 2'd0;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'd1;
`endif
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg;
  logic            illegal_reg;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    op_result;
  logic               op_illegal;

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    acc_shifted;
  assign acc_shifted = acc << 1;
`endif

  // A new op may enter when idle, or when the held result drains this same cycle.
  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign shamt         = bus.operand_b[SHAMT_W-1:0];

  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.illegal   = illegal_reg;

  // Single-cycle datapath; in the iterative build SLL only finishes here when shamt is 0.
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (bus.alu_control)
      OP_AND: op_result = bus.operand_a & bus.operand_b;
      OP_OR:  op_result = bus.operand_a | bus.operand_b;
      OP_ADD: op_result = bus.operand_a + bus.operand_b;
      OP_SUB: op_result = bus.operand_a - bus.operand_b;
      OP_SLT: op_result = {{(XLEN-1){1'b0}},
                           ($signed(bus.operand_a) < $signed(bus.operand_b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: op_result = bus.operand_a << shamt;
`else
      OP_SLL: op_result = bus.operand_a;
`endif
      OP_NOP: op_result = '0;
      default: begin
        op_result  = '0;
        op_illegal = 1'b1;
      end
    endcase
  end

  // Control FSM plus result registers; an accept always wins over draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc         <= '0;
      cnt         <= '0;
`endif
    end else if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
      if ((bus.alu_control == OP_SLL) && (shamt != '0)) begin
        acc   <= bus.operand_a;
        cnt   <= shamt;
        state <= SHIFT;
      end else
`endif
      begin
        result_reg  <= op_result;
        zero_reg    <= (op_result == '0);
        illegal_reg <= op_illegal;
        state       <= DONE;
      end
    end else begin
      case (state)
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          acc <= acc_shifted;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result_reg  <= acc_shifted;
            zero_reg    <= (acc_shifted == '0);
            illegal_reg <= 1'b0;
            state       <= DONE;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a transaction-level model (queue of
// expected results with due cycles) checked every cycle, plus literal vectors.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n     = 0;
  bit   fresh = 1'b1;

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int now);
    exp_t e;
    int   s;
    s     = int'(b[4:0]);
    e.ill = 1'b0;
    e.due = now + 1;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: begin
        e.res = a << s;
`ifndef ALU_FAST_SHIFT_EN
        e.due = now + 1 + s;
`endif
      end
      4'b1111: e.res = 32'd0;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    bit ov_exp, ir_exp;
    n++;
    if (rst) begin
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_result",    bus.result,              32'd0);
      chk("rst_zero",      {31'd0, bus.zero},      32'd0);
      chk("rst_illegal",   {31'd0, bus.illegal},   32'd0);
      q.delete();
      fresh = 1'b1;
    end else begin
      ov_exp = (q.size() > 0) && (n >= q[0].due);
      ir_exp = (q.size() == 0) || (ov_exp && bus.out_ready);
      chk("mdl_out_valid", {31'd0, bus.out_valid}, {31'd0, ov_exp});
      chk("mdl_in_ready",  {31'd0, bus.in_ready},  {31'd0, ir_exp});
      if (ov_exp) begin
        chk("mdl_result",  bus.result,            q[0].res);
        chk("mdl_zero",    {31'd0, bus.zero},    {31'd0, q[0].z});
        chk("mdl_illegal", {31'd0, bus.illegal}, {31'd0, q[0].ill});
      end else if (fresh) begin
        chk("fresh_result",  bus.result,            32'd0);
        chk("fresh_zero",    {31'd0, bus.zero},    32'd0);
        chk("fresh_illegal", {31'd0, bus.illegal}, 32'd0);
      end
      if (ov_exp && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && ir_exp) begin
        q.push_back(model(bus.alu_control, bus.operand_a, bus.operand_b, n));
        fresh = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present an op and hold it until the handshake completes; returns at posedge+2.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    bus.in_valid    = 1'b1;
    bus.alu_control = c;
    bus.operand_a   = a;
    bus.operand_b   = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept code=%b", c);
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid and compare against literal expectations including latency.
  task automatic wait_result(input string name, input logic [31:0] er, input logic ez,
                             input logic ei, input int elat);
    bit got = 1'b0;
    int lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
    end else begin
      chk({name, "_result"},  bus.result,            er);
      chk({name, "_zero"},    {31'd0, bus.zero},    {31'd0, ez});
      chk({name, "_illegal"}, {31'd0, bus.illegal}, {31'd0, ei});
      chk({name, "_latency"}, lat,                   elat);
    end
    @(posedge clk); #2;
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  localparam int SLL34_LAT =
`ifdef ALU_FAST_SHIFT_EN
    1;
`else
    5;
`endif

  initial begin
    vec_t stream[7];
    logic [31:0] held;
    stream[0] = '{4'b0010, 32'd10,          32'd20};
    stream[1] = '{4'b0000, 32'hF0F0_1234,   32'h0FF0_FFFF};
    stream[2] = '{4'b1110, 32'h0000_0001,   32'd3};
    stream[3] = '{4'b0110, 32'd0,           32'd1};
    stream[4] = '{4'b0111, 32'hFFFF_FFFF,   32'd0};
    stream[5] = '{4'b1010, 32'd9,           32'd9};
    stream[6] = '{4'b1110, 32'h8000_0001,   32'd1};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'd0;
    bus.operand_a   = '0;
    bus.operand_b   = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #2;

    send(4'b0010, 32'hFFFF_FFFF, 32'd1);        wait_result("add_wrap", 32'd0, 1'b1, 1'b0, 1);
    send(4'b0110, 32'd5, 32'd7);                wait_result("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    send(4'b0111, 32'h8000_0000, 32'd1);        wait_result("slt_neg", 32'd1, 1'b0, 1'b0, 1);
    send(4'b0111, 32'd1, 32'h8000_0000);        wait_result("slt_pos", 32'd0, 1'b1, 1'b0, 1);
    send(4'b1110, 32'd3, 32'd4);                wait_result("sll_3_4", 32'd48, 1'b0, 1'b0, SLL34_LAT);
    send(4'b1110, 32'h0000_1234, 32'd0);        wait_result("sll_b0", 32'h0000_1234, 1'b0, 1'b0, 1);
    send(4'b1110, 32'h0000_5678, 32'h0000_0020); wait_result("sll_hi_bits", 32'h0000_5678, 1'b0, 1'b0, 1);
    send(4'b0001, 32'hA000_0005, 32'h0500_0050); wait_result("or", 32'hA500_0055, 1'b0, 1'b0, 1);
    send(4'b0101, 32'd3, 32'd4);                wait_result("illegal", 32'd0, 1'b1, 1'b1, 1);
    send(4'b1111, 32'd3, 32'd4);                wait_result("nop", 32'd0, 1'b1, 1'b0, 1);

    // Backpressure: result held for 3 cycles, then drain and accept together.
    bus.out_ready = 1'b0;
    send(4'b0010, 32'd2, 32'd3);
    @(negedge clk);
    held = bus.result;
    chk("bp_first_result", held, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_result",   bus.result,            32'd5);
      chk("bp_hold_zero",     {31'd0, bus.zero},    32'd0);
      chk("bp_hold_illegal",  {31'd0, bus.illegal}, 32'd0);
      chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    send(4'b0110, 32'd10, 32'd3);
    wait_result("bp_next_sub", 32'd7, 1'b0, 1'b0, 1);

    // Back-to-back stream, checked by the model.
    foreach (stream[i]) send(stream[i].c, stream[i].a, stream[i].b);
    repeat (10) @(posedge clk);
    #2;

    // Reset in the middle of a long shift.
    send(4'b1110, 32'd1, 32'd31);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("abort_result",    bus.result,              32'd0);
    repeat (40) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
